sort_frame_loader: RTL and testbench

- Upstream feeder for the parallel sorting network.
- Accepts a valid/ready word stream and assembles one frame of 2**LOG_INPUT_NUM words into the flat vector x.
- Pads short frames (terminated by s_last) with a sentinel so pad words sort to the tail, then issues a one-cycle x_valid.
- Holds x stable and blocks further input until the sorter reports y_valid; only one frame is in flight.

---
 rtl/sort_pkg.sv | 25 ++
 rtl/sort_frame_loader.sv | 100 ++++++++++
 tb/tb_sort_frame_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sorting-network feeder/unloader pair.
package sort_pkg;

  localparam int unsigned PAD_MAX_W = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Sentinel that sorts to the tail of a frame; callers truncate to their width.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input int unsigned dw,
                                                     input bit signed_el,
                                                     input bit ascending);
    logic [PAD_MAX_W-1:0] v;
    logic [PAD_MAX_W-1:0] mask;
    mask = (dw >= PAD_MAX_W) ? '1 : ((PAD_MAX_W'(1) << dw) - PAD_MAX_W'(1));
    v    = ascending ? mask : '0;
    if (signed_el && dw > 0 && dw <= PAD_MAX_W) v[dw-1] = ~ascending;
    return v;
  endfunction

endpackage

// File: rtl/sort_frame_loader.sv
// Assembles a stream of words into one padded frame for the sorting network
// and holds it until the sorter signals completion.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int unsigned LOG_INPUT_NUM = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          SIGNED        = 1'b0,
  parameter bit          ASCENDING     = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DATA_WIDTH-1:0]                    s_data,
  input  logic                                     s_valid,
  input  logic                                     s_last,
  output logic                                     s_ready,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] x,
  output logic                                     x_valid,
  input  logic                                     y_valid,
  output logic [LOG_INPUT_NUM:0]                   frame_len,
  output logic                                     busy
);

  localparam int unsigned N  = 2 ** LOG_INPUT_NUM;
  localparam int unsigned IW = LOG_INPUT_NUM;
  localparam int unsigned LW = LOG_INPUT_NUM + 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] PAD_WORD =
    DATA_WIDTH'(pad_value(DATA_WIDTH, SIGNED, ASCENDING));

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    run;
  logic [DATA_WIDTH-1:0]   slot [N];
  logic                    accept;
  logic                    at_last;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;

  // run holds s_ready low for the first cycle after reset release.
  assign s_ready = run && (state == FILL);
  assign x_valid = (state == ISSUE);
  assign busy    = (state != FILL);
  assign accept  = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);
  assign wr_en   = accept || (state == PAD);
  assign wr_data = (state == PAD) ? PAD_WORD : s_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      idx       <= '0;
      frame_len <= '0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        FILL: begin
          if (accept) begin
            if (s_last || at_last) begin
              frame_len <= LW'(idx) + LW'(1);
              if (at_last) begin
                state <= ISSUE;
              end else begin
                state <= PAD;
                idx   <= idx + IW'(1);
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        PAD: begin
          if (at_last) state <= ISSUE;
          else         idx   <= idx + IW'(1);
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (y_valid) begin
            idx   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Frame storage: decoded per-slot write enable, intentionally not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_en && (idx == IW'(i))) slot[i] <= wr_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign x[DATA_WIDTH*g +: DATA_WIDTH] = slot[g];
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench: three loader configurations share one stimulus stream.
module tb_sort_frame_loader;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [2:0]      len;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        y_valid;
  logic        s_ready_a, s_ready_b, s_ready_c;
  logic [31:0] x_a, x_b, x_c;
  logic        x_valid_a, x_valid_b, x_valid_c;
  logic [2:0]  fl_a, fl_b, fl_c;
  logic        busy_a, busy_b, busy_c;

  int tests = 0;
  int fails = 0;
  int xv_count = 0;
  int frames_pushed = 0;
  frame_t sb[$];
  frame_t mf;

  sort_frame_loader #(.LOG_INPUT_NUM(2), .DATA_WIDTH(8), .SIGNED(1'b0), .ASCENDING(1'b1)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_a), .x(x_a), .x_valid(x_valid_a), .y_valid(y_valid),
    .frame_len(fl_a), .busy(busy_a));

  sort_frame_loader #(.LOG_INPUT_NUM(2), .DATA_WIDTH(8), .SIGNED(1'b1), .ASCENDING(1'b1)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_b), .x(x_b), .x_valid(x_valid_b), .y_valid(y_valid),
    .frame_len(fl_b), .busy(busy_b));

  sort_frame_loader #(.LOG_INPUT_NUM(2), .DATA_WIDTH(8), .SIGNED(1'b1), .ASCENDING(1'b0)) dut_c (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_c), .x(x_c), .x_valid(x_valid_c), .y_valid(y_valid),
    .frame_len(fl_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference: real elements in order, remaining slots filled with the pad.
  function automatic logic [31:0] exp_x(input frame_t f, input logic [7:0] p);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = (i < int'(f.len)) ? f.d[i] : p;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && x_valid_a) begin
      xv_count++;
      if (sb.size() == 0) begin
        timeout("unexpected_x_valid");
      end else begin
        mf = sb.pop_front();
        check("x_asc_unsigned", 64'(x_a), 64'(exp_x(mf, 8'hFF)));
        check("x_asc_signed",   64'(x_b), 64'(exp_x(mf, 8'h7F)));
        check("x_desc_signed",  64'(x_c), 64'(exp_x(mf, 8'h80)));
        check("frame_len",      64'(fl_a), 64'(mf.len));
        check("frame_len_c",    64'(fl_c), 64'(mf.len));
        check("x_valid_b",      64'(x_valid_b), 64'(1));
        check("x_valid_c",      64'(x_valid_c), 64'(1));
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input bit last, input bit bubbly);
    int n;
    if (bubbly) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    s_data = d; s_last = last; s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready_a) break;
      n++;
      if (n > 50) begin timeout("accept_wait"); break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_issue(input int exp_lat, input bit yv_in_issue);
    int c;
    bit found;
    found = 1'b0;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (x_valid_a) begin found = 1'b1; break; end
    end
    if (!found) timeout("issue_wait");
    else check("issue_latency", 64'(c), 64'(exp_lat));
    if (yv_in_issue) y_valid = 1'b1;
    @(posedge clk); #1;
    y_valid = 1'b0;
    @(negedge clk);
    check("wait_s_ready", 64'(s_ready_a), 64'(0));
    check("wait_busy",    64'(busy_a),    64'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input frame_t f, input bit bubbly, input bit yv_in_issue);
    sb.push_back(f);
    frames_pushed++;
    for (int k = 0; k < int'(f.len); k++) send_word(f.d[k], k == int'(f.len) - 1, bubbly);
    wait_issue(1 + 4 - int'(f.len), yv_in_issue);
  endtask

  task automatic release_frame(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    y_valid = 1'b1;
    @(posedge clk); #1;
    y_valid = 1'b0;
    @(negedge clk);
    check("release_s_ready", 64'(s_ready_a), 64'(1));
    @(posedge clk); #1;
  endtask

  function automatic frame_t mk(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3,
                                input int len);
    frame_t f;
    f.d[0] = d0; f.d[1] = d1; f.d[2] = d2; f.d[3] = d3;
    f.len = 3'(len);
    return f;
  endfunction

  initial begin
    frame_t f;
    rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; y_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_s_ready", 64'(s_ready_a), 64'(0));
      check("rst_x_valid", 64'(x_valid_a), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_s_ready",   64'(s_ready_a), 64'(1));
    check("reset_busy",      64'(busy_a),    64'(0));
    check("reset_frame_len", 64'(fl_a),      64'(0));
    check("reset_x_valid",   64'(x_valid_a), 64'(0));

    // y_valid in FILL is ignored
    y_valid = 1'b1;
    @(posedge clk); #1;
    y_valid = 1'b0;
    @(negedge clk);
    check("fill_yv_s_ready", 64'(s_ready_a), 64'(1));
    check("fill_yv_busy",    64'(busy_a),    64'(0));
    @(posedge clk); #1;

    // Full frame, y_valid pulsed in ISSUE, then input held off in WAIT
    send_frame(mk(8'h30, 8'h10, 8'h40, 8'h20, 4), 1'b0, 1'b1);
    s_data = 8'hAA; s_last = 1'b1; s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_x",       64'(x_a),       64'h20401030);
      check("hold_s_ready", 64'(s_ready_a), 64'(0));
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    release_frame(0);

    send_frame(mk(8'h05, 8'h07, 8'h00, 8'h00, 2), 1'b0, 1'b0);
    release_frame(2);
    send_frame(mk(8'h00, 8'h00, 8'h00, 8'h00, 1), 1'b0, 1'b0);
    release_frame(1);

    // Bubbly random frames
    for (int n = 0; n < 3; n++) begin
      f = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(1, 4)));
      send_frame(f, 1'b1, 1'b0);
      release_frame(int'($urandom_range(0, 4)));
    end

    // Reset mid-frame
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_x_valid", 64'(x_valid_a), 64'(0));
      check("midrst_s_ready", 64'(s_ready_a), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_frame(mk(8'h9A, 8'h01, 8'hFF, 8'h5C, 4), 1'b0, 1'b0);
    release_frame(0);

    repeat (3) @(negedge clk);
    check("x_valid_count", 64'(xv_count), 64'(frames_pushed));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
